// File: rtl/axil_regfile_if.sv
// AXI4-Lite slave bus bundle for axil_regfile; the slave modport is the register
// file side, the master modport is the bus driver side.
interface axil_regfile_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axil_regfile.sv
// AXI4-Lite register file with flat register outputs and per-register write strobes.
// Optional macro AXIL_WSTRB_EN enables byte-lane write strobes (default: full-word writes).
module axil_regfile #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 12,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       resetn,
  axil_regfile_if.slave              axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse,
  output logic                       dbg_wr_state_o
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  localparam logic [0:0] W_COLLECT = 1'b0;
  localparam logic [0:0] W_RESP    = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake semantics on every channel: a transfer happens on a rising edge
  // where valid && ready are both high; ready never depends on valid.
  logic [0:0]          wstate_q, wstate_d;
  logic                aw_held_q, aw_held_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic                w_held_q, w_held_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic             aw_hs, w_hs, ar_hs;
  logic             wr_in_range, rd_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_val;
  logic             unused_ok;

  assign axi.s_axi_awready = !aw_held_q && !bvalid_q;
  assign axi.s_axi_wready  = !w_held_q && !bvalid_q;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_arready = !rvalid_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = rresp_q;

  assign aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
  assign w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
  assign ar_hs = axi.s_axi_arvalid && axi.s_axi_arready;

  assign wr_in_range = {1'b0, aw_idx_q} < NUM_REGS_L;
  assign rd_idx      = axi.s_axi_araddr[ADDR_W-1:ADDR_LSB];
  assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_L;

  assign reg_wr_pulse   = pulse_q;
  assign dbg_wr_state_o = wstate_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign reg_q[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

`ifdef AXIL_WSTRB_EN
  assign unused_ok = ^{axi.s_axi_awaddr[ADDR_LSB-1:0], axi.s_axi_araddr[ADDR_LSB-1:0]};
`else
  assign unused_ok = ^{axi.s_axi_awaddr[ADDR_LSB-1:0], axi.s_axi_araddr[ADDR_LSB-1:0], wstrb_q};
`endif

  // Write path: AW and W land in independent holding registers; the commit
  // happens one edge after both are held, so bvalid rises two cycles after the later one.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = axi.s_axi_awaddr[ADDR_W-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axi.s_axi_wdata;
      wstrb_d  = axi.s_axi_wstrb;
    end

    case (wstate_q)
      W_COLLECT: begin
        if (aw_held_q && w_held_q) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          wstate_d  = W_RESP;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_in_range && aw_idx_q == IDX_W'(i)) begin
              pulse_d[i] = 1'b1;
`ifdef AXIL_WSTRB_EN
              for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
              end
`else
              regs_d[i] = wdata_q;
`endif
            end
          end
        end
      end
      W_RESP: begin
        if (axi.s_axi_bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_COLLECT;
        end
      end
      default: wstate_d = W_COLLECT;
    endcase
  end

  // Read path sees regs_q, so a read on a commit edge returns the old value.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && axi.s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_val : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate_q  <= W_COLLECT;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      pulse_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile: hand-computed vectors checked with immediate assertions.
module tb_axil_regfile;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 12;
  localparam int NUM_REGS = 16;

  logic                       clk = 1'b0;
  logic                       resetn = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        reg_wr_pulse;
  logic                       dbg_wr_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] mdl [NUM_REGS];
  logic [1:0]        resp;
  logic [DATA_W-1:0] rd;

  axil_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axil_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RESET_VAL('0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .axi(axi),
    .reg_q(reg_q),
    .reg_wr_pulse(reg_wr_pulse),
    .dbg_wr_state_o(dbg_wr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s_reg%0d", tag, i), 64'(reg_q[i*DATA_W +: DATA_W]), 64'(mdl[i]));
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    logic aw_hs, w_hs;
    axi.s_axi_awaddr = a; axi.s_axi_wdata = d; axi.s_axi_wstrb = s;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_bready = 1'b0;
    for (int k = 0; k < 20 && (axi.s_axi_awvalid || axi.s_axi_wvalid); k++) begin
      aw_hs = axi.s_axi_awvalid && axi.s_axi_awready;
      w_hs  = axi.s_axi_wvalid && axi.s_axi_wready;
      tick();
      if (aw_hs) axi.s_axi_awvalid = 1'b0;
      if (w_hs)  axi.s_axi_wvalid  = 1'b0;
    end
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    for (int k = 0; k < 20 && !axi.s_axi_bvalid; k++) tick();
    check("wr_bvalid_seen", 64'(axi.s_axi_bvalid), 64'd1);
    r = axi.s_axi_bresp;
    axi.s_axi_bready = 1'b1; tick(); axi.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    logic hs;
    axi.s_axi_araddr = a; axi.s_axi_arvalid = 1'b1; axi.s_axi_rready = 1'b0;
    for (int k = 0; k < 20 && axi.s_axi_arvalid; k++) begin
      hs = axi.s_axi_arready;
      tick();
      if (hs) axi.s_axi_arvalid = 1'b0;
    end
    axi.s_axi_arvalid = 1'b0;
    for (int k = 0; k < 20 && !axi.s_axi_rvalid; k++) tick();
    check("rd_rvalid_seen", 64'(axi.s_axi_rvalid), 64'd1);
    d = axi.s_axi_rdata; r = axi.s_axi_rresp;
    axi.s_axi_rready = 1'b1; tick(); axi.s_axi_rready = 1'b0;
  endtask

  initial begin
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0; axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;

    // Reset state
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
    check("rst_awready", 64'(axi.s_axi_awready), 64'd1);
    check("rst_wready", 64'(axi.s_axi_wready), 64'd1);
    check("rst_arready", 64'(axi.s_axi_arready), 64'd1);
    check("rst_bvalid", 64'(axi.s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(axi.s_axi_rvalid), 64'd0);
    check("rst_bresp", 64'(axi.s_axi_bresp), 64'd0);
    check("rst_rdata", 64'(axi.s_axi_rdata), 64'd0);
    check("rst_pulse", 64'(reg_wr_pulse), 64'd0);
    check("rst_state", 64'(dbg_wr_state), 64'd0);
    check_regs("rst");

    // AW in cycle 1, W in cycle 4, bvalid in cycle 6
    axi.s_axi_awaddr = 12'h004; axi.s_axi_awvalid = 1'b1; tick(); axi.s_axi_awvalid = 1'b0;
    check("aw_only_awready", 64'(axi.s_axi_awready), 64'd0);
    check("aw_only_wready", 64'(axi.s_axi_wready), 64'd1);
    tick(); tick();
    axi.s_axi_wdata = 32'hA5A5_1234; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
    tick(); axi.s_axi_wvalid = 1'b0;
    check("late_w_bvalid_c5", 64'(axi.s_axi_bvalid), 64'd0);
    check("late_w_wready_held", 64'(axi.s_axi_wready), 64'd0);
    tick();
    mdl[1] = 32'hA5A5_1234;
    check("late_w_bvalid_c6", 64'(axi.s_axi_bvalid), 64'd1);
    check("late_w_bresp", 64'(axi.s_axi_bresp), 64'd0);
    check("late_w_pulse", 64'(reg_wr_pulse), 64'h0002);
    check("late_w_state", 64'(dbg_wr_state), 64'd1);
    check_regs("late_w");
    tick();
    check("late_w_pulse_drop", 64'(reg_wr_pulse), 64'd0);
    check("late_w_bvalid_hold", 64'(axi.s_axi_bvalid), 64'd1);
    axi.s_axi_bready = 1'b1; tick(); axi.s_axi_bready = 1'b0;
    check("late_w_bvalid_clr", 64'(axi.s_axi_bvalid), 64'd0);
    check("late_w_awready_back", 64'(axi.s_axi_awready), 64'd1);
    check("late_w_wready_back", 64'(axi.s_axi_wready), 64'd1);

    // W before AW to reg 7
    axi.s_axi_wdata = 32'h0000_1234; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
    tick(); axi.s_axi_wvalid = 1'b0;
    check("w_first_wready", 64'(axi.s_axi_wready), 64'd0);
    check("w_first_awready", 64'(axi.s_axi_awready), 64'd1);
    axi.s_axi_awaddr = 12'h01C; axi.s_axi_awvalid = 1'b1; tick(); axi.s_axi_awvalid = 1'b0;
    check("w_first_bvalid_early", 64'(axi.s_axi_bvalid), 64'd0);
    tick();
    mdl[7] = 32'h0000_1234;
    check("w_first_bvalid", 64'(axi.s_axi_bvalid), 64'd1);
    check("w_first_pulse", 64'(reg_wr_pulse), 64'h0080);
    axi.s_axi_bready = 1'b1; tick(); axi.s_axi_bready = 1'b0;

    // Out-of-range write: idx 16
    axi.s_axi_awaddr = 12'h040; axi.s_axi_wdata = 32'hDEAD_BEEF; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    tick(); axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    check("oor_bvalid_early", 64'(axi.s_axi_bvalid), 64'd0);
    tick();
    check("oor_bvalid", 64'(axi.s_axi_bvalid), 64'd1);
    check("oor_bresp", 64'(axi.s_axi_bresp), 64'h2);
    check("oor_pulse", 64'(reg_wr_pulse), 64'd0);
    check_regs("oor");
    axi.s_axi_bready = 1'b1; tick(); axi.s_axi_bready = 1'b0;
    check("oor_bvalid_clr", 64'(axi.s_axi_bvalid), 64'd0);

    // Byte strobes on reg 2
    do_write(12'h008, 32'h1122_3344, 4'hF, resp);
    mdl[2] = 32'h1122_3344;
    check("strb_full_bresp", 64'(resp), 64'd0);
    do_write(12'h008, 32'hFFFF_FFFF, 4'h5, resp);
`ifdef AXIL_WSTRB_EN
    mdl[2] = 32'h11FF_33FF;
`else
    mdl[2] = 32'hFFFF_FFFF;
`endif
    check("strb5_bresp", 64'(resp), 64'd0);
    do_read(12'h008, rd, resp);
    check("strb5_rdata", 64'(rd), 64'(mdl[2]));
    check("strb5_rresp", 64'(resp), 64'd0);
    do_write(12'h00B, 32'h0000_0000, 4'h0, resp);
`ifndef AXIL_WSTRB_EN
    mdl[2] = 32'h0000_0000;
`endif
    check("strb0_bresp", 64'(resp), 64'd0);
    do_read(12'h009, rd, resp);
    check("strb0_rdata", 64'(rd), 64'(mdl[2]));
    check_regs("strb");

    // Out-of-range reads
    do_read(12'h040, rd, resp);
    check("oor_rd_rdata", 64'(rd), 64'd0);
    check("oor_rd_rresp", 64'(resp), 64'h2);
    do_read(12'hFFC, rd, resp);
    check("oor_rd_top_rdata", 64'(rd), 64'd0);
    check("oor_rd_top_rresp", 64'(resp), 64'h2);
    do_read(12'h004, rd, resp);
    check("rd_reg1", 64'(rd), 64'hA5A5_1234);

    // bready low for 5 cycles, then a new AW
    axi.s_axi_awaddr = 12'h014; axi.s_axi_wdata = 32'h0000_0005; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    tick(); axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    tick();
    mdl[5] = 32'h0000_0005;
    axi.s_axi_awaddr = 12'h018; axi.s_axi_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_bvalid_%0d", i), 64'(axi.s_axi_bvalid), 64'd1);
      check($sformatf("bp_bresp_%0d", i), 64'(axi.s_axi_bresp), 64'd0);
      check($sformatf("bp_awready_%0d", i), 64'(axi.s_axi_awready), 64'd0);
      check($sformatf("bp_wready_%0d", i), 64'(axi.s_axi_wready), 64'd0);
      tick();
    end
    check("bp_bvalid_after5", 64'(axi.s_axi_bvalid), 64'd1);
    axi.s_axi_bready = 1'b1; tick(); axi.s_axi_bready = 1'b0;
    check("bp_bvalid_clr", 64'(axi.s_axi_bvalid), 64'd0);
    check("bp_awready_back", 64'(axi.s_axi_awready), 64'd1);
    tick(); axi.s_axi_awvalid = 1'b0;
    check("bp_new_aw_held", 64'(axi.s_axi_awready), 64'd0);
    axi.s_axi_wdata = 32'h0000_0066; axi.s_axi_wvalid = 1'b1; tick(); axi.s_axi_wvalid = 1'b0;
    tick();
    mdl[6] = 32'h0000_0066;
    check("bp_new_bvalid", 64'(axi.s_axi_bvalid), 64'd1);
    check("bp_new_pulse", 64'(reg_wr_pulse), 64'h0040);
    axi.s_axi_bready = 1'b1; tick(); axi.s_axi_bready = 1'b0;
    check_regs("bp");

    // Read of reg 3 on the commit edge of 0x55 to reg 3
    axi.s_axi_awaddr = 12'h00C; axi.s_axi_wdata = 32'h0000_0055; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
    tick(); axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_araddr = 12'h00C; axi.s_axi_arvalid = 1'b1;
    tick(); axi.s_axi_arvalid = 1'b0;
    mdl[3] = 32'h0000_0055;
    check("raw_rvalid", 64'(axi.s_axi_rvalid), 64'd1);
    check("raw_rdata_old", 64'(axi.s_axi_rdata), 64'd0);
    check("raw_rresp", 64'(axi.s_axi_rresp), 64'd0);
    check("raw_bvalid", 64'(axi.s_axi_bvalid), 64'd1);
    check("raw_arready_low", 64'(axi.s_axi_arready), 64'd0);
    check_regs("raw");
    axi.s_axi_bready = 1'b1; axi.s_axi_rready = 1'b1; tick();
    axi.s_axi_bready = 1'b0; axi.s_axi_rready = 1'b0;
    check("raw_rvalid_clr", 64'(axi.s_axi_rvalid), 64'd0);
    check("raw_arready_back", 64'(axi.s_axi_arready), 64'd1);
    do_read(12'h00C, rd, resp);
    check("raw_rdata_new", 64'(rd), 64'h55);

    // Reset with AW held and W pending
    axi.s_axi_awaddr = 12'h010; axi.s_axi_awvalid = 1'b1; tick(); axi.s_axi_awvalid = 1'b0;
    check("mid_rst_aw_held", 64'(axi.s_axi_awready), 64'd0);
    axi.s_axi_wdata = 32'h0000_0077; axi.s_axi_wvalid = 1'b1; resetn = 1'b0;
    tick(); resetn = 1'b1; axi.s_axi_wvalid = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    check("mid_rst_bvalid", 64'(axi.s_axi_bvalid), 64'd0);
    check("mid_rst_awready", 64'(axi.s_axi_awready), 64'd1);
    check("mid_rst_wready", 64'(axi.s_axi_wready), 64'd1);
    check("mid_rst_pulse", 64'(reg_wr_pulse), 64'd0);
    check_regs("mid_rst");
    tick();
    check("mid_rst_no_commit", 64'(axi.s_axi_bvalid), 64'd0);
    check("mid_rst_pulse2", 64'(reg_wr_pulse), 64'd0);
    do_write(12'h010, 32'h0000_0099, 4'hF, resp);
    mdl[4] = 32'h0000_0099;
    check("post_rst_bresp", 64'(resp), 64'd0);
    check_regs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 12, AXI address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; range 1 to 2^(ADDR_W-ADDR_LSB), where ADDR_LSB = log2(DATA_W/8).
REQ-004 SHALL have parameter RESET_VAL, default 0, DATA_W-bit reset value of every register.
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have ports s_axi_awaddr in ADDR_W, s_axi_awvalid in 1, s_axi_awready out 1: write-address channel.
REQ-008 SHALL have ports s_axi_wdata in DATA_W, s_axi_wstrb in DATA_W/8, s_axi_wvalid in 1, s_axi_wready out 1: write-data channel.
REQ-009 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write-response channel.
REQ-010 SHALL have ports s_axi_araddr in ADDR_W, s_axi_arvalid in 1, s_axi_arready out 1: read-address channel.
REQ-011 SHALL have ports s_axi_rdata out DATA_W, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read-data channel.
REQ-012 SHALL have port reg_q, output, NUM_REGS*DATA_W, flattened register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port reg_wr_pulse, output, NUM_REGS, one-cycle strobe per register on each committed write.

Function
REQ-014 Address decode SHALL use idx = addr[ADDR_W-1:ADDR_LSB] and ignore addr[ADDR_LSB-1:0]; idx >= NUM_REGS is out of range.
REQ-015 AW and W SHALL be accepted independently, in either order or in the same cycle, each into its own holding register with a held flag.
REQ-016 s_axi_awready SHALL equal !aw_held && !s_axi_bvalid; s_axi_wready SHALL equal !w_held && !s_axi_bvalid; both are combinational from registered state.
REQ-017 Write FSM states: W_COLLECT (waiting for AW and/or W), W_RESP (bvalid high).
REQ-018 In W_COLLECT, when aw_held && w_held, the block SHALL commit on that edge: update the register if in range, clear both held flags, set bvalid, and enter W_RESP.
REQ-019 The response SHALL be bvalid high in the second cycle after the later of the two handshake cycles.
REQ-020 bresp SHALL be 2'b00 (OKAY) when in range and 2'b10 (SLVERR) when out of range; an out-of-range write SHALL modify no register and pulse no strobe.
REQ-021 bvalid and bresp SHALL hold stable until bvalid && bready; then the FSM SHALL return to W_COLLECT, with awready and wready high in the next cycle.
REQ-022 reg_wr_pulse[idx] SHALL be high for exactly the cycle after the commit edge.
REQ-023 s_axi_arready SHALL equal !s_axi_rvalid.
REQ-024 On an AR handshake, rdata and rresp SHALL be registered, and rvalid SHALL go high the next cycle.
REQ-025 An in-range read SHALL return the register value with rresp 2'b00; an out-of-range read SHALL return 0 with rresp 2'b10.
REQ-026 rvalid, rdata and rresp SHALL hold stable until rvalid && rready; rvalid then clears, and arready is high the next cycle.
REQ-027 Read and write paths SHALL operate concurrently; a read sampled on the same edge as a commit to the same register SHALL return the pre-write value.
REQ-028 At most one write and one read SHALL be outstanding; there is no ID or reordering.

Reset
REQ-029 While resetn is low at a rising edge, every register SHALL load RESET_VAL.
REQ-030 While resetn is low at a rising edge, aw_held, w_held, bvalid, rvalid and reg_wr_pulse SHALL clear, bresp, rresp and rdata SHALL clear to 0, and the FSM SHALL enter W_COLLECT.
REQ-031 Reset mid-transaction SHALL discard any held AW/W and any pending response; no partial write occurs.

Configuration
REQ-032 Macro AXIL_WSTRB_EN defined: byte lane b SHALL be written only if wstrb[b]=1; wstrb all-zero commits an OKAY response with no data change, but the strobe still pulses.
REQ-033 Macro AXIL_WSTRB_EN undefined: wstrb SHALL be ignored and all DATA_W bits written on every in-range commit.

Verification
REQ-034 AW 0x004 in cycle 1, then W 0xA5A5_1234 with strb 0xF in cycle 4 -> bvalid in cycle 6 with bresp 0; reg_q[1] = 0xA5A5_1234; reg_wr_pulse[1] high one cycle.
REQ-035 AW+W in the same cycle to 0x040 with NUM_REGS=16 -> bresp 2'b10; no register changes; reg_wr_pulse all 0.
REQ-036 With AXIL_WSTRB_EN: reg 2 = 0x1122_3344, write 0xFFFF_FFFF with strb 0x5 -> reads back 0x11FF_33FF; without the macro -> 0xFFFF_FFFF.
REQ-037 bready held low for 5 cycles after bvalid -> bvalid, bresp stable; awready and wready low throughout; a new AW accepted the cycle after bready rises.
REQ-038 Read of reg 3 on the same edge as a commit of 0x55 to reg 3 (previous value 0x0) -> rdata 0x0; a subsequent read returns 0x55.
REQ-039 resetn low for one edge while AW is held and W is pending -> no bvalid, reg_q all RESET_VAL, awready high the next cycle.
